// File: rtl/txrx_defs.sv
// rtl/txrx_defs.sv - shared frame-format constants and FSM encodings for the serial link
package txrx_defs;

    localparam int                  TXRX_DATA_W   = 55;
    localparam int                  TXRX_SYNC_W   = 6;
    localparam logic [TXRX_SYNC_W-1:0] TXRX_SYNC_PAT = 6'b01_1111;

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_RECV = 2'd1,
        ST_LOAD = 2'd2
    } rx_state_t;

endpackage

// File: rtl/rcv_protocol_sync_detect.sv
// rtl/rcv_protocol_sync_detect.sv - start-sequence shift register and comparator
//
// Ports:
//   clk    - clock, rising edge
//   rst    - synchronous active-high reset, clears the shift register
//   clear  - synchronous clear of the shift register (wins over en)
//   en     - shift bit_in into the register this cycle
//   bit_in - serial line sample
//   match  - combinational: the value the register is about to take equals SYNC_PAT
module sync_detect #(
    parameter int                  SYNC_W   = txrx_defs::TXRX_SYNC_W,
    parameter logic [SYNC_W-1:0]   SYNC_PAT = txrx_defs::TXRX_SYNC_PAT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    input  logic bit_in,
    output logic match
);

    logic [SYNC_W-1:0] sr;
    logic [SYNC_W-1:0] sr_next;

    assign sr_next = {sr[SYNC_W-2:0], bit_in};

    // Compare against the post-shift value so the FSM can leave HUNT on the
    // same edge that samples the final sync bit.
    assign match = en && (sr_next == SYNC_PAT);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sr <= '0;
        end else if (en) begin
            sr <= sr_next;
        end
    end

endmodule

// File: rtl/rcv_protocol.sv
// rtl/rcv_protocol.sv - same-clock serial frame receiver with ready/overrun handshake
//
// Ports:
//   clk     - clock, every register updates on the rising edge
//   rst     - synchronous active-high reset
//   S_Data  - serial line, one bit per clk, MSB first, idles low
//   clr_rdy - consumer acknowledge, clears rdy and overrun on the next edge
//   RX_Data - last complete payload, MSB = first payload bit received
//   rdy     - RX_Data holds an unacknowledged frame
//   overrun - sticky, a frame completed while rdy was already high
//   busy    - high exactly while payload bits are being received
module rcv_protocol
    import txrx_defs::*;
#(
    parameter int                DATA_W   = TXRX_DATA_W,
    parameter int                SYNC_W   = TXRX_SYNC_W,
    parameter logic [SYNC_W-1:0] SYNC_PAT = TXRX_SYNC_PAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              S_Data,
    input  logic              clr_rdy,
    output logic [DATA_W-1:0] RX_Data,
    output logic              rdy,
    output logic              overrun,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    rx_state_t         state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] payload;
    logic              sync_match;

    // Sync matching only runs in HUNT so payload contents can never restart
    // reception; the register is wiped on LOAD so each frame needs a full pattern.
    sync_detect #(
        .SYNC_W   (SYNC_W),
        .SYNC_PAT (SYNC_PAT)
    ) u_sync_detect (
        .clk    (clk),
        .rst    (rst),
        .clear  (state == ST_LOAD),
        .en     (state == ST_HUNT),
        .bit_in (S_Data),
        .match  (sync_match)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_HUNT;
            cnt     <= '0;
            payload <= '0;
            RX_Data <= '0;
            rdy     <= 1'b0;
            overrun <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (state)
                ST_HUNT: begin
                    if (sync_match) begin
                        state <= ST_RECV;
                        cnt   <= CNT_W'(DATA_W);
                        busy  <= 1'b1;
                    end
                end
                ST_RECV: begin
                    payload <= {payload[DATA_W-2:0], S_Data};
                    cnt     <= cnt - 1'b1;
                    // cnt == 1 marks the last payload sample; the counter
                    // only reaches 0 once the FSM has left RECV.
                    if (cnt == CNT_W'(1)) begin
                        state <= ST_LOAD;
                        busy  <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    RX_Data <= payload;
                    state   <= ST_HUNT;
                end
                default: begin
                    state <= ST_HUNT;
                    busy  <= 1'b0;
                end
            endcase

            // A completing frame takes priority over an acknowledge in the
            // same cycle, so the consumer never loses sight of new data.
            if (state == ST_LOAD) begin
                rdy <= 1'b1;
                if (rdy && !clr_rdy) begin
                    overrun <= 1'b1;
                end
            end else if (clr_rdy) begin
                rdy     <= 1'b0;
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rcv_protocol.sv
// tb/tb_rcv_protocol.sv - directed self-checking bench for rcv_protocol
module tb_rcv_protocol;

    localparam int DW = 55;

    logic          clk;
    logic          rst;
    logic          S_Data;
    logic          clr_rdy;
    logic [DW-1:0] RX_Data;
    logic          rdy;
    logic          overrun;
    logic          busy;

    int checks = 0;
    int errors = 0;

    rcv_protocol dut (
        .clk     (clk),
        .rst     (rst),
        .S_Data  (S_Data),
        .clr_rdy (clr_rdy),
        .RX_Data (RX_Data),
        .rdy     (rdy),
        .overrun (overrun),
        .busy    (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one line bit, let one rising edge sample it, then look 1ns later.
    task automatic send_bit(input logic b);
        S_Data = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_sync();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
    endtask

    task automatic send_payload(input logic [DW-1:0] p);
        for (int i = DW - 1; i >= 0; i--) begin
            send_bit(p[i]);
        end
    endtask

    // Sync + payload + the idle bit sampled during the LOAD cycle.
    task automatic send_frame(input logic [DW-1:0] p);
        send_sync();
        send_payload(p);
        send_bit(1'b0);
    endtask

    task automatic pulse_clr();
        clr_rdy = 1'b1;
        send_bit(1'b0);
        clr_rdy = 1'b0;
    endtask

    logic [DW-1:0] pa;
    logic [DW-1:0] pb;
    logic [DW-1:0] pc;
    logic [DW-1:0] pe;

    initial begin
        pa = 55'h2A_AAAA_AAAA_AAAA;
        pb = 55'h55_1234_5678_9ABC;
        pc = 55'h0F_0F0F_00FF_1357;
        pe = {6'b011111, 49'b0};

        rst     = 1'b1;
        S_Data  = 1'b0;
        clr_rdy = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("reset_rdy",     64'(rdy),     64'd0);
        chk("reset_overrun", 64'(overrun), 64'd0);
        chk("reset_busy",    64'(busy),    64'd0);
        chk("reset_rx_data", 64'(RX_Data), 64'd0);
        rst = 1'b0;
        send_bit(1'b0);

        // Single frame: rdy must rise on the 57th edge counting the one that
        // samples the last sync bit.
        send_sync();
        chk("single_busy_after_sync", 64'(busy), 64'd1);
        send_payload(pa);
        chk("single_rdy_not_yet", 64'(rdy),  64'd0);
        chk("single_busy_done",   64'(busy), 64'd0);
        send_bit(1'b0);
        chk("single_rdy",     64'(rdy),     64'd1);
        chk("single_rx_data", 64'(RX_Data), 64'(pa));
        chk("single_overrun", 64'(overrun), 64'd0);
        pulse_clr();
        chk("single_clr_rdy", 64'(rdy), 64'd0);

        // Embedded sync pattern in the payload must not restart reception.
        send_frame(pe);
        chk("embed_rdy",     64'(rdy),     64'd1);
        chk("embed_rx_data", 64'(RX_Data), 64'(pe));
        pulse_clr();
        for (int i = 0; i < 60; i++) begin
            send_bit(1'b0);
        end
        chk("embed_no_second_rdy", 64'(rdy),  64'd0);
        chk("embed_idle_busy",     64'(busy), 64'd0);

        // Overrun: two frames back-to-back with no acknowledge.
        send_frame(pa);
        send_frame(pb);
        chk("ovr_rdy",     64'(rdy),     64'd1);
        chk("ovr_flag",    64'(overrun), 64'd1);
        chk("ovr_rx_data", 64'(RX_Data), 64'(pb));
        pulse_clr();
        chk("ovr_clr_rdy",  64'(rdy),     64'd0);
        chk("ovr_clr_flag", 64'(overrun), 64'd0);

        // Acknowledge coincident with the LOAD cycle of frame 2.
        send_frame(pa);
        send_sync();
        send_payload(pc);
        clr_rdy = 1'b1;
        send_bit(1'b0);
        clr_rdy = 1'b0;
        chk("coinc_rdy",     64'(rdy),     64'd1);
        chk("coinc_overrun", 64'(overrun), 64'd0);
        chk("coinc_rx_data", 64'(RX_Data), 64'(pc));

        // Reset after 20 payload bits discards the partial frame.
        send_sync();
        for (int i = DW - 1; i >= DW - 20; i--) begin
            send_bit(pb[i]);
        end
        rst = 1'b1;
        send_bit(1'b0);
        rst = 1'b0;
        chk("rstmid_busy",    64'(busy),    64'd0);
        chk("rstmid_rdy",     64'(rdy),     64'd0);
        chk("rstmid_rx_data", 64'(RX_Data), 64'd0);
        for (int i = 0; i < 40; i++) begin
            send_bit(1'b0);
        end
        chk("rstmid_no_rdy", 64'(rdy), 64'd0);
        send_frame(pb);
        chk("rstmid_next_rdy",     64'(rdy),     64'd1);
        chk("rstmid_next_rx_data", 64'(RX_Data), 64'(pb));
        pulse_clr();

        // Near-miss patterns must not lock; only the true 011111 does.
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        chk("near_busy_a", 64'(busy), 64'd0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        chk("near_busy_b", 64'(busy), 64'd0);
        send_frame(pc);
        chk("near_rdy",     64'(rdy),     64'd1);
        chk("near_rx_data", 64'(RX_Data), 64'(pc));
        chk("near_overrun", 64'(overrun), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
